// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the MAXNET sequencing controller.
package maxnet_pkg;

  localparam int unsigned N_PU_DEF     = 4;
  localparam int unsigned MAX_ITER_DEF = 100;
  localparam int unsigned STATUS_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MULT,
    S_SUM,
    S_CHECK,
    S_FEEDBACK,
    S_DONE
  } state_t;

  typedef logic [STATUS_W-1:0] status_t;

  localparam status_t ST_WIN     = 2'b00;
  localparam status_t ST_ZERO    = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/one_hot_detect.sv
// Classifies the unit nonzero flags as none / exactly one / several set,
// and reports the index of the lowest set bit.
module one_hot_detect #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     s,
  output logic             zero,
  output logic             one,
  output logic             many,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    zero = (s == '0);
    one  = !zero && ((s & (s - N'(1))) == '0);
    many = !zero && !one;
    idx  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (s[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Sequences the MAXNET datapath (load / multiply / sum / check / feedback)
// until a single unit survives, all units die, or the iteration limit hits.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned  N_PU     = N_PU_DEF,
  parameter int unsigned  MAX_ITER = MAX_ITER_DEF,
  parameter int unsigned  ITER_W   = 8,
  localparam int unsigned IDX_W    = (N_PU > 1) ? $clog2(N_PU) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_PU-1:0]   s,
  output logic              sel_init,
  output logic              load_x,
  output logic              load_mult,
  output logic              load_sum,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  winner,
  output logic [1:0]        status,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic              sel_init_d, load_x_d, load_mult_d, load_sum_d, busy_d, done_d;
  logic [IDX_W-1:0]  winner_d;
  status_t           status_d;
  logic [ITER_W-1:0] iter_d;

  logic              det_zero, det_one, det_many;
  logic [IDX_W-1:0]  det_idx;

  one_hot_detect #(
    .N     (N_PU),
    .IDX_W (IDX_W)
  ) u_detect (
    .s    (s),
    .zero (det_zero),
    .one  (det_one),
    .many (det_many),
    .idx  (det_idx)
  );

  // Next state and next-cycle outputs; strobes are decoded from the state
  // being entered so the registered outputs line up with the state.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner;
    status_d    = status;
    iter_d      = iter_count;
    sel_init_d  = 1'b0;
    load_x_d    = 1'b0;
    load_mult_d = 1'b0;
    load_sum_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INIT;
          iter_d   = '0;
          winner_d = '0;
          status_d = ST_WIN;
        end
      end
      S_INIT:  state_d = S_MULT;
      S_MULT:  state_d = S_SUM;
      S_SUM:   state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_DONE;
        if (det_one) begin
          winner_d = det_idx;
          status_d = ST_WIN;
        end else if (det_zero) begin
          winner_d = '0;
          status_d = ST_ZERO;
        end else if (det_many && (iter_count == ITER_MAX)) begin
          winner_d = '0;
          status_d = ST_TIMEOUT;
        end else begin
          state_d = S_FEEDBACK;
        end
      end
      S_FEEDBACK: begin
        state_d = S_MULT;
        if (iter_count < ITER_MAX) iter_d = iter_count + ITER_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    sel_init_d  = (state_d == S_INIT);
    load_x_d    = (state_d == S_INIT) || (state_d == S_FEEDBACK);
    load_mult_d = (state_d == S_MULT);
    load_sum_d  = (state_d == S_SUM);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_init   <= 1'b0;
      load_x     <= 1'b0;
      load_mult  <= 1'b0;
      load_sum   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      winner     <= '0;
      status     <= ST_WIN;
      iter_count <= '0;
    end else begin
      state_q    <= state_d;
      sel_init   <= sel_init_d;
      load_x     <= load_x_d;
      load_mult  <= load_mult_d;
      load_sum   <= load_sum_d;
      busy       <= busy_d;
      done       <= done_d;
      winner     <= winner_d;
      status     <= status_d;
      iter_count <= iter_d;
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: default instance plus a MAX_ITER=3
// instance for the short timeout case.
module tb_maxnet_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       start_t = 1'b0;
  logic [3:0] s = 4'b0000;

  logic       sel_init, load_x, load_mult, load_sum, busy, done;
  logic [1:0] winner, status;
  logic [7:0] iter_count;
  logic       sel_init_t, load_x_t, load_mult_t, load_sum_t, busy_t, done_t;
  logic [1:0] winner_t, status_t;
  logic [7:0] iter_count_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // {sel_init, load_x, load_mult, load_sum, busy, done}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_INIT  = 6'b110010;
  localparam logic [5:0] C_MULT  = 6'b001010;
  localparam logic [5:0] C_SUM   = 6'b000110;
  localparam logic [5:0] C_CHECK = 6'b000010;
  localparam logic [5:0] C_FB    = 6'b010010;
  localparam logic [5:0] C_DONE  = 6'b000011;

  maxnet_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .s          (s),
    .sel_init   (sel_init),
    .load_x     (load_x),
    .load_mult  (load_mult),
    .load_sum   (load_sum),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .status     (status),
    .iter_count (iter_count)
  );

  maxnet_controller #(.MAX_ITER(3)) dut_t (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start_t),
    .s          (s),
    .sel_init   (sel_init_t),
    .load_x     (load_x_t),
    .load_mult  (load_mult_t),
    .load_sum   (load_sum_t),
    .busy       (busy_t),
    .done       (done_t),
    .winner     (winner_t),
    .status     (status_t),
    .iter_count (iter_count_t)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] ctl(input bit t);
    return t ? {sel_init_t, load_x_t, load_mult_t, load_sum_t, busy_t, done_t}
             : {sel_init, load_x, load_mult, load_sum, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input bit t, input logic [5:0] exp);
    logic [5:0] obs;
    obs = ctl(t);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
  endtask

  // Advance one cycle and check strobe exclusivity on both instances.
  task automatic tick();
    logic ok;
    @(posedge clock);
    #1;
    ok = ($countones({load_x, load_mult, load_sum}) <= 1)
      && ($countones({load_x_t, load_mult_t, load_sum_t}) <= 1)
      && (!sel_init || load_x) && (!sel_init_t || load_x_t);
    n_checks++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL strobe_onehot: observed %b%b%b/%b%b%b expected at most one",
                load_x, load_mult, load_sum, load_x_t, load_mult_t, load_sum_t);
  endtask

  // Pulse (or hold) start, then step until done, checking each phase.
  // s is presented as sa up to the first CHECK, sb to the second, sc after.
  task automatic run(input bit t, input bit hold, input logic [3:0] sa,
                     input logic [3:0] sb, input logic [3:0] sc,
                     input int limit, output int n);
    n = 0;
    s = sa;
    if (t) start_t = 1'b1; else start = 1'b1;
    while (n < limit) begin
      tick();
      n++;
      if (!hold) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
      s = (n <= 4) ? sa : (n <= 8) ? sb : sc;
      if (ctl(t)[0]) break;
      if (n == 1) chk_ctl("phase_init", t, C_INIT);
      else begin
        case (n % 4)
          2:       chk_ctl("phase_mult", t, C_MULT);
          3:       chk_ctl("phase_sum", t, C_SUM);
          0:       chk_ctl("phase_check", t, C_CHECK);
          default: chk_ctl("phase_feedback", t, C_FB);
        endcase
      end
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk_ctl("reset_ctl", 1'b0, C_IDLE);
    chk_ctl("reset_ctl_t", 1'b1, C_IDLE);
    chk("reset_winner", 32'(winner), 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_iter", 32'(iter_count), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Single winner on first check; start taken on first edge after reset.
    run(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 20, cyc);
    chk("s1_done_cycle", 32'(cyc), 32'd5);
    chk_ctl("s1_done_ctl", 1'b0, C_DONE);
    chk("s1_winner", 32'(winner), 32'd2);
    chk("s1_status", 32'(status), 32'd0);
    chk("s1_iter", 32'(iter_count), 32'd0);
    tick();
    chk_ctl("s1_idle_ctl", 1'b0, C_IDLE);
    chk("s1_winner_held", 32'(winner), 32'd2);

    // Two feedback iterations before a single survivor.
    run(1'b0, 1'b0, 4'b1011, 4'b1001, 4'b1000, 40, cyc);
    chk("s2_done_cycle", 32'(cyc), 32'd13);
    chk_ctl("s2_done_ctl", 1'b0, C_DONE);
    chk("s2_winner", 32'(winner), 32'd3);
    chk("s2_status", 32'(status), 32'd0);
    chk("s2_iter", 32'(iter_count), 32'd2);
    tick();

    // All units dead.
    run(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 20, cyc);
    chk("s3_done_cycle", 32'(cyc), 32'd5);
    chk("s3_winner", 32'(winner), 32'd0);
    chk("s3_status", 32'(status), 32'd1);
    chk("s3_iter", 32'(iter_count), 32'd0);
    tick();

    // Timeout with MAX_ITER=3.
    run(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 40, cyc);
    chk("s4_done_cycle", 32'(cyc), 32'd17);
    chk_ctl("s4_done_ctl", 1'b1, C_DONE);
    chk("s4_winner", 32'(winner_t), 32'd0);
    chk("s4_status", 32'(status_t), 32'd2);
    chk("s4_iter", 32'(iter_count_t), 32'd3);
    tick();
    chk_ctl("s4_idle_ctl", 1'b1, C_IDLE);
    chk_ctl("s4_default_untouched", 1'b0, C_IDLE);

    // Timeout at the default limit of 100 iterations.
    run(1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 500, cyc);
    chk("s4b_done_cycle", 32'(cyc), 32'd405);
    chk("s4b_status", 32'(status), 32'd2);
    chk("s4b_iter", 32'(iter_count), 32'd100);
    tick();

    // Asynchronous reset in SUM, then a clean run.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_ctl("s5_in_sum", 1'b0, C_SUM);
    #2 reset_n = 1'b0;
    #1;
    chk_ctl("s5_async_ctl", 1'b0, C_IDLE);
    chk("s5_async_winner", 32'(winner), 32'd0);
    chk("s5_async_status", 32'(status), 32'd0);
    chk("s5_async_iter", 32'(iter_count), 32'd0);
    tick();
    reset_n = 1'b1;
    run(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 20, cyc);
    chk("s5_done_cycle", 32'(cyc), 32'd5);
    chk("s5_winner", 32'(winner), 32'd1);
    chk("s5_status", 32'(status), 32'd0);
    tick();

    // Start held high through the run and during DONE.
    run(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, 20, cyc);
    chk("s6_done_cycle", 32'(cyc), 32'd5);
    chk("s6_winner", 32'(winner), 32'd0);
    tick();
    chk_ctl("s6_no_restart", 1'b0, C_IDLE);
    tick();
    chk_ctl("s6_restart_init", 1'b0, C_INIT);
    start = 1'b0;
    s = 4'b0100;
    cyc = 0;
    while (cyc < 10 && !done) begin
      tick();
      cyc++;
    end
    chk("s6_second_done_cycle", 32'(cyc), 32'd4);
    chk("s6_second_winner", 32'(winner), 32'd2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 The block SHALL take parameter N_PU, default 4, meaning the number of process units sequenced in parallel.
REQ-002 The block SHALL take parameter MAX_ITER, default 100, meaning the iteration limit before timeout.
REQ-003 The block SHALL take parameter ITER_W, default 8, meaning the width of the iteration counter.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE.
REQ-007 The block SHALL have port s, input, N_PU bits: per-unit nonzero (post-ReLU) flags from the process units.
REQ-008 The block SHALL have port sel_init, output, 1 bit: input mux select; 1 = external inputs, 0 = fed-back unit outputs.
REQ-009 The block SHALL have port load_x, output, 1 bit: one-cycle strobe that loads the unit input registers.
REQ-010 The block SHALL have port load_mult, output, 1 bit: one-cycle strobe that captures the multiplier results.
REQ-011 The block SHALL have port load_sum, output, 1 bit: one-cycle strobe that captures the adder-tree result.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port winner, output, clog2(N_PU) bits: index of the single surviving unit.
REQ-015 The block SHALL have port status, output, 2 bits: 00 = winner, 01 = all zero, 10 = timeout.
REQ-016 The block SHALL have port iter_count, output, ITER_W bits: number of completed feedback iterations.

Function
REQ-017 The block SHALL implement the states IDLE, INIT, MULT, SUM, CHECK, FEEDBACK and DONE, one cycle each except IDLE.
REQ-018 In IDLE with start=1, the block SHALL go to INIT and clear iter_count to 0.
REQ-019 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-020 INIT SHALL assert load_x=1 and sel_init=1, then go to MULT.
REQ-021 MULT SHALL assert load_mult=1, then go to SUM.
REQ-022 SUM SHALL assert load_sum=1, then go to CHECK.
REQ-023 CHECK SHALL sample s and take exactly one branch: one bit set -> DONE, winner=index, status=00; zero bits set -> DONE, status=01, winner=0; more than one bit set and iter_count==MAX_ITER -> DONE, status=10, winner=0; otherwise -> FEEDBACK.
REQ-024 FEEDBACK SHALL assert load_x=1 with sel_init=0, increment iter_count, then go to MULT.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-026 winner and status SHALL be registered in CHECK and held until the next start is accepted.
REQ-027 Latency SHALL be: done high 5 cycles after the start-sampling edge when no feedback occurs, plus 4 cycles per feedback iteration.
REQ-028 start SHALL be ignored in every state other than IDLE; a start coincident with DONE SHALL NOT begin a new run.
REQ-029 Outside their named states, load_x, load_mult, load_sum and done SHALL be 0; at most one load strobe SHALL be high in any cycle.
REQ-030 sel_init SHALL be 0 in every state except INIT.
REQ-031 iter_count SHALL saturate at MAX_ITER and never wrap.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force IDLE, with sel_init, load_x, load_mult, load_sum, busy and done at 0, winner=0, status=00 and iter_count=0, including mid-run.
REQ-033 After reset_n is released, the block SHALL accept start on the first rising edge.

Structure
REQ-034 Package maxnet_pkg SHALL hold the state enum, the status encodings (ST_WIN, ST_ZERO, ST_TIMEOUT) and the N_PU and MAX_ITER defaults.
REQ-035 A sub-module one_hot_detect SHALL compute, combinationally from s, the flags zero, one and many plus the index of the set bit.

Verification
REQ-036 Scenario: start pulse, s=4'b0100 in CHECK -> done 5 cycles after start, winner=2, status=00, iter_count=0, strobe order load_x/load_mult/load_sum.
REQ-037 Scenario: s=4'b1011, then 4'b1001, then 4'b1000 at successive CHECKs -> two FEEDBACK cycles with sel_init=0, done at cycle 13, winner=3, iter_count=2.
REQ-038 Scenario: s=4'b0000 at the first CHECK -> status=01, winner=0, done at cycle 5.
REQ-039 Scenario: MAX_ITER=3 with s held at 4'b1111 -> status=10, iter_count=3, done at cycle 17.
REQ-040 Scenario: reset_n pulsed low during SUM -> all outputs 0 asynchronously; a new start completes normally.
REQ-041 Scenario: start held high throughout a run and asserted during DONE -> no restart until IDLE is reached; every cycle has at most one load strobe high (assertion).
